// File: rtl/slc3_io_responder.sv
// SLC-3 memory-mapped I/O responder: switch reads, hex register writes,
// plus the synchronized and debounced Continue button pulse for the CPU.
module slc3_io_responder #(
  parameter logic [15:0] IO_ADDR    = 16'hFFFF,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  SW,
  input  logic        Continue_n,
  input  logic [15:0] MAR,
  input  logic [15:0] Data_from_CPU,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Pause_Req,
  output logic        Io_Hit,
  output logic        Io_Rdy,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] Hex_Reg,
  output logic        Cont_Pulse
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);
  localparam int unsigned DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_TC = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [15:0] rd_data;
  logic [9:0]  sw_s1;
  logic [9:0]  sw_s2;

  logic             cont_s1;
  logic             cont_s2;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             press_q;

  assign Io_Hit = (Mem_OE | Mem_WE) && (MAR == IO_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  // Io_Rdy and Data_to_CPU are registered so they are high exactly while in RESP.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      rd_data     <= '0;
      Io_Rdy      <= 1'b0;
      Data_to_CPU <= '0;
      Hex_Reg     <= '0;
    end else begin
      Io_Rdy      <= 1'b0;
      Data_to_CPU <= '0;
      case (state)
        IDLE: begin
          if (Io_Hit) begin
            if (Mem_WE) begin
              Hex_Reg <= Data_from_CPU;
              Io_Rdy  <= 1'b1;
              state   <= RESP;
            end else begin
              rd_data <= {6'b0, sw_s2};
              lat_cnt <= LAT_INIT;
              if (READ_LAT == 1) begin
                Io_Rdy      <= 1'b1;
                Data_to_CPU <= {6'b0, sw_s2};
                state       <= RESP;
              end else begin
                state <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            Io_Rdy      <= 1'b1;
            Data_to_CPU <= rd_data;
            state       <= RESP;
          end
        end
        RESP: state <= DRAIN;
        DRAIN: begin
          if (!Mem_OE && !Mem_WE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pause_Req is judged at the flip edge; the pulse follows one cycle later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cont_s1    <= 1'b1;
      cont_s2    <= 1'b1;
      deb_level  <= 1'b1;
      deb_cnt    <= '0;
      press_q    <= 1'b0;
      Cont_Pulse <= 1'b0;
    end else begin
      cont_s1    <= Continue_n;
      cont_s2    <= cont_s1;
      press_q    <= 1'b0;
      Cont_Pulse <= press_q;
      if (cont_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_TC) begin
        deb_level <= cont_s2;
        deb_cnt   <= '0;
        press_q   <= ~cont_s2 & Pause_Req;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slc3_io_responder.sv
// Directed bench for slc3_io_responder: switch reads, hex writes, reset abort,
// Continue debounce and pause gating (READ_LAT=2, DEB_CYCLES=4).
module tb_slc3_io_responder;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  SW;
  logic        Continue_n;
  logic [15:0] MAR;
  logic [15:0] Data_from_CPU;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Pause_Req;
  logic        Io_Hit;
  logic        Io_Rdy;
  logic [15:0] Data_to_CPU;
  logic [15:0] Hex_Reg;
  logic        Cont_Pulse;

  int n_cmp = 0;
  int n_mis = 0;

  slc3_io_responder #(
    .IO_ADDR   (16'hFFFF),
    .READ_LAT  (2),
    .DEB_CYCLES(4)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .SW           (SW),
    .Continue_n   (Continue_n),
    .MAR          (MAR),
    .Data_from_CPU(Data_from_CPU),
    .Mem_OE       (Mem_OE),
    .Mem_WE       (Mem_WE),
    .Pause_Req    (Pause_Req),
    .Io_Hit       (Io_Hit),
    .Io_Rdy       (Io_Rdy),
    .Data_to_CPU  (Data_to_CPU),
    .Hex_Reg      (Hex_Reg),
    .Cont_Pulse   (Cont_Pulse)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Read at IO_ADDR with Mem_OE held through DRAIN; tick 1 is the accept edge.
  task automatic do_read(input string tag, input logic [15:0] exp_data);
    int lat;
    int extra;
    lat = 0;
    extra = 0;
    MAR = 16'hFFFF;
    Mem_OE = 1'b1;
    #1;
    chk({tag, "_hit"}, 32'(Io_Hit), 32'd1);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (Io_Rdy) begin
        lat = i;
        chk({tag, "_data"}, 32'(Data_to_CPU), 32'(exp_data));
      end
    end
    chk({tag, "_lat"}, lat, 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Io_Rdy) extra++;
    end
    chk({tag, "_drain_rdy"}, extra, 32'd0);
    chk({tag, "_data_idle"}, 32'(Data_to_CPU), 32'd0);
    Mem_OE = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_write(input string tag, input logic [15:0] addr, input logic [15:0] data,
                          input logic oe, input logic exp_hit, input logic [15:0] exp_hex);
    int extra;
    extra = 0;
    MAR = addr;
    Data_from_CPU = data;
    Mem_WE = 1'b1;
    Mem_OE = oe;
    #1;
    chk({tag, "_hit"}, 32'(Io_Hit), 32'(exp_hit));
    tick();
    chk({tag, "_rdy"}, 32'(Io_Rdy), 32'(exp_hit));
    chk({tag, "_hex"}, 32'(Hex_Reg), 32'(exp_hex));
    chk({tag, "_rdata"}, 32'(Data_to_CPU), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Io_Rdy) extra++;
    end
    chk({tag, "_extra_rdy"}, extra, 32'd0);
    Mem_WE = 1'b0;
    Mem_OE = 1'b0;
    tick();
    tick();
  endtask

  // Button held low for low_cycles samples, observed for total cycles.
  task automatic cont_run(input int low_cycles, input int total, input logic pause,
                          output int pulses, output int first);
    pulses = 0;
    first = 0;
    Pause_Req = pause;
    Continue_n = 1'b0;
    for (int i = 1; i <= total; i++) begin
      tick();
      if (Cont_Pulse) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i == low_cycles) Continue_n = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;
    int cnt;

    Reset_n = 1'b0;
    SW = 10'h000;
    Continue_n = 1'b1;
    MAR = 16'h0000;
    Data_from_CPU = 16'h0000;
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    Pause_Req = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", 32'(Io_Rdy), 32'd0);
    chk("rst_data", 32'(Data_to_CPU), 32'd0);
    chk("rst_hex", 32'(Hex_Reg), 32'd0);
    chk("rst_cont", 32'(Cont_Pulse), 32'd0);
    Reset_n = 1'b1;
    tick();

    SW = 10'h006;
    repeat (3) tick();
    do_read("rd006", 16'h0006);
    SW = 10'h052;
    repeat (3) tick();
    do_read("rd052", 16'h0052);

    do_write("wr1234", 16'hFFFF, 16'h1234, 1'b0, 1'b1, 16'h1234);
    do_write("wr3000", 16'h3000, 16'hBEEF, 1'b0, 1'b0, 16'h1234);
    do_write("wr_prio", 16'hFFFF, 16'h00AB, 1'b1, 1'b1, 16'h00AB);

    // Reset asserted while the read is waiting in RD_WAIT.
    MAR = 16'hFFFF;
    Mem_OE = 1'b1;
    tick();
    chk("mid_rd_rdy_before", 32'(Io_Rdy), 32'd0);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(Io_Rdy), 32'd0);
    chk("mid_rst_data", 32'(Data_to_CPU), 32'd0);
    chk("mid_rst_hex", 32'(Hex_Reg), 32'd0);
    tick();
    Mem_OE = 1'b0;
    tick();
    Reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Io_Rdy) cnt++;
    end
    chk("post_rst_no_rdy", cnt, 32'd0);
    do_read("rd_after_rst", 16'h0052);

    cont_run(3, 12, 1'b1, pulses, first);
    chk("glitch_pulses", pulses, 32'd0);

    cont_run(10, 22, 1'b1, pulses, first);
    chk("hold_pulses", pulses, 32'd1);
    chk("hold_latency", first, 32'd7);

    // Press while not paused, then pause arrives while still held.
    cnt = 0;
    Pause_Req = 1'b0;
    Continue_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Cont_Pulse) cnt++;
    end
    Pause_Req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Cont_Pulse) cnt++;
    end
    Continue_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Cont_Pulse) cnt++;
    end
    chk("unpaused_press", cnt, 32'd0);

    cont_run(10, 22, 1'b1, pulses, first);
    chk("repress_pulses", pulses, 32'd1);
    chk("repress_latency", first, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
